// File: rtl/mmul_stream_driver.sv
// -----------------------------------------------------------------------------
// mmul_stream_driver
//
// Host-side front end for a 3x3 signed matmul engine.
// - Collects 18 operand elements from a valid/ready input stream. They arrive
//   row-major: A(0,0)..A(2,2), then B(0,0)..B(2,2).
// - Packs the elements into the engine's A/B operand buses.
// - Clears the engine, enables it, and waits for done.
// - Captures the packed result and streams the 9 result elements out on a
//   valid/ready output stream. out_last marks C(2,2).
//
// Parameters:
//   ELEM_W       element width; the packed buses are 9*ELEM_W wide.
//   RESULT_WAIT  cycles between sampling eng_done=1 and latching eng_result.
//                Must be >= 1.
//   TIMEOUT      maximum RUN cycles before an abort. Must be >= 2.
//                Exists only when MMUL_DRV_TIMEOUT_EN is defined.
//
// Configuration macro: MMUL_DRV_TIMEOUT_EN
//   Defined:   a RUN-cycle watchdog aborts a job when eng_done never arrives.
//              The abort sets the sticky err flag, pulses eng_reset for one
//              cycle, and returns to LOAD_A.
//   Undefined: the driver waits in RUN indefinitely and err is tied low.
//
// Ports:
//   clk, reset_n                 clock (rising edge) and async active-low reset
//   in_data/in_valid/in_ready    operand input stream
//   out_data/out_valid/out_ready result output stream
//   out_last                     high with the final result element
//   eng_reset, eng_enable        engine control (eng_reset is active-high)
//   eng_mat_a, eng_mat_b         packed operands; element (i,j) sits at
//                                [(i*3+j)*ELEM_W +: ELEM_W]
//   eng_result, eng_done         packed result and done from the engine
//   busy                         low only when idle (LOAD_A with idx=0)
//   err                          sticky timeout flag
//
// Every output is a register or a decode of registered state. No input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module mmul_stream_driver #(
  parameter int ELEM_W      = 8,
  parameter int RESULT_WAIT = 1
`ifdef MMUL_DRV_TIMEOUT_EN
  ,
  parameter int TIMEOUT     = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ELEM_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ELEM_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  eng_reset,
  output logic                  eng_enable,
  output logic [9*ELEM_W-1:0]   eng_mat_a,
  output logic [9*ELEM_W-1:0]   eng_mat_b,
  input  logic [9*ELEM_W-1:0]   eng_result,
  input  logic                  eng_done,
  output logic                  busy,
  output logic                  err
);

  localparam int BUS_W  = 9 * ELEM_W;
  localparam int WAIT_W = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;
`ifdef MMUL_DRV_TIMEOUT_EN
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_CLR    = 3'd2,
    S_RUN    = 3'd3,
    S_WAIT   = 3'd4,
    S_SEND   = 3'd5,
    S_ABORT  = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  // High only in the first cycle after reset release. While it is high the
  // engine stays in reset and the input stream is held off.
  logic                init_q, init_d;
  logic                err_q, err_d;
`ifdef MMUL_DRV_TIMEOUT_EN
  logic [TO_W-1:0]     run_cnt_q, run_cnt_d;
`endif

  logic [BUS_W-1:0]    mat_a_q, mat_b_q, result_q;

  logic                in_fire_s;
  logic                out_fire_s;
  logic                load_a_s;
  logic                load_b_s;
  logic                result_load_s;

  // Select element k (0..8) of a packed bus; indices beyond 8 read as zero.
  function automatic logic [ELEM_W-1:0] elem_sel(input logic [BUS_W-1:0] bus,
                                                 input logic [3:0]       k);
    logic [ELEM_W-1:0] e;
    case (k)
      4'd0:    e = bus[0*ELEM_W +: ELEM_W];
      4'd1:    e = bus[1*ELEM_W +: ELEM_W];
      4'd2:    e = bus[2*ELEM_W +: ELEM_W];
      4'd3:    e = bus[3*ELEM_W +: ELEM_W];
      4'd4:    e = bus[4*ELEM_W +: ELEM_W];
      4'd5:    e = bus[5*ELEM_W +: ELEM_W];
      4'd6:    e = bus[6*ELEM_W +: ELEM_W];
      4'd7:    e = bus[7*ELEM_W +: ELEM_W];
      4'd8:    e = bus[8*ELEM_W +: ELEM_W];
      default: e = {ELEM_W{1'b0}};
    endcase
    return e;
  endfunction

  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid && out_ready;

  // State register and control counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_LOAD_A;
      idx_q      <= 4'd0;
      wait_cnt_q <= {WAIT_W{1'b0}};
      init_q     <= 1'b1;
      err_q      <= 1'b0;
`ifdef MMUL_DRV_TIMEOUT_EN
      run_cnt_q  <= {TO_W{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      init_q     <= init_d;
      err_q      <= err_d;
`ifdef MMUL_DRV_TIMEOUT_EN
      run_cnt_q  <= run_cnt_d;
`endif
    end
  end

  // Next-state, element index and wait/timeout counter logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wait_cnt_d    = wait_cnt_q;
    init_d        = 1'b0;
    err_d         = err_q;
    load_a_s      = 1'b0;
    load_b_s      = 1'b0;
    result_load_s = 1'b0;
`ifdef MMUL_DRV_TIMEOUT_EN
    run_cnt_d     = run_cnt_q;
`endif
    case (state_q)
      S_LOAD_A: begin
        if (in_fire_s) begin
          load_a_s = 1'b1;
          if (idx_q == 4'd8) begin
            idx_d   = 4'd0;
            state_d = S_LOAD_B;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_LOAD_B: begin
        if (in_fire_s) begin
          load_b_s = 1'b1;
          if (idx_q == 4'd8) begin
            idx_d   = 4'd0;
            state_d = S_CLR;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_CLR: begin
        state_d = S_RUN;
`ifdef MMUL_DRV_TIMEOUT_EN
        run_cnt_d = {TO_W{1'b0}};
`endif
      end
      S_RUN: begin
        // A done that is already high on RUN entry is taken immediately.
        if (eng_done) begin
          state_d    = S_WAIT;
          wait_cnt_d = {WAIT_W{1'b0}};
        end else begin
`ifdef MMUL_DRV_TIMEOUT_EN
          if (run_cnt_q == TO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_ABORT;
          end else begin
            run_cnt_d = run_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
          end
`else
          state_d = S_RUN;
`endif
        end
      end
      S_WAIT: begin
        // The engine's result register settles after done, so the latch
        // happens on the last of RESULT_WAIT wait cycles.
        if (wait_cnt_q == WAIT_W'(RESULT_WAIT - 1)) begin
          result_load_s = 1'b1;
          idx_d         = 4'd0;
          state_d       = S_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      S_SEND: begin
        if (out_fire_s) begin
          if (idx_q == 4'd8) begin
            idx_d   = 4'd0;
            state_d = S_LOAD_A;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_ABORT: begin
        idx_d   = 4'd0;
        state_d = S_LOAD_A;
      end
      default: begin
        idx_d   = 4'd0;
        state_d = S_LOAD_A;
      end
    endcase
  end

  // Operand and result holding registers. They change only on load strobes,
  // so the operands stay stable from CLR through SEND.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mat_a_q  <= {BUS_W{1'b0}};
      mat_b_q  <= {BUS_W{1'b0}};
      result_q <= {BUS_W{1'b0}};
    end else begin
      if (load_a_s) begin
        mat_a_q[idx_q*ELEM_W +: ELEM_W] <= in_data;
      end
      if (load_b_s) begin
        mat_b_q[idx_q*ELEM_W +: ELEM_W] <= in_data;
      end
      if (result_load_s) begin
        result_q <= eng_result;
      end
    end
  end

  // Output decode from registered state only.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = {ELEM_W{1'b0}};
    eng_reset  = init_q;
    eng_enable = 1'b0;
    busy       = !((state_q == S_LOAD_A) && (idx_q == 4'd0));
    case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        in_ready = !init_q;
      end
      S_CLR, S_ABORT: begin
        eng_reset = 1'b1;
      end
      S_RUN: begin
        eng_enable = 1'b1;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = (idx_q == 4'd8);
        out_data  = elem_sel(result_q, idx_q);
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign eng_mat_a = mat_a_q;
  assign eng_mat_b = mat_b_q;
  assign err       = err_q;

endmodule
